// File: rtl/emul_pkg.sv
// Shared types and helpers for the emul multiplier sequencer.
// State encoding, mode constants and accumulator width derivation.
package emul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_MAC = 1'b1;

  function automatic int acc_width(input int width, input int guard);
    return 2 * width + guard;
  endfunction

endpackage

// File: rtl/emul_lat_cnt.sv
// Loadable down-counter timing the emul pipeline latency.
// Holds its value whenever enable is low; saturates at zero.
module emul_lat_cnt #(
  parameter int CW = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enable_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/emul_seq_param.sv
// Sequencer driving an external pipelined multiplier; returns the product
// (MUL) or accumulates it into a guarded register with sticky carry (MAC).
module emul_seq_param
  import emul_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int LATENCY   = 2,
  parameter  int ACC_GUARD = 4,
  localparam int ACC_W     = acc_width(WIDTH, ACC_GUARD)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               start,
  input  logic               mode,
  input  logic               clear_acc,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [ACC_W-1:0]   x,
  output logic               ovf,
  output logic [WIDTH-1:0]   emul_a,
  output logic [WIDTH-1:0]   emul_b,
  input  logic [2*WIDTH-1:0] emul_x
);

  localparam int            CW       = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY - 1);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [ACC_W-1:0]   x_q, x_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   emul_a_q, emul_a_d;
  logic [WIDTH-1:0]   emul_b_q, emul_b_d;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;
  logic [CW-1:0]      cnt;
  logic               ready_w;
  logic [ACC_W:0]     mac_sum;

  assign ready_w = (state_q == IDLE) || (state_q == DONE);
  assign mac_sum = {1'b0, x_q} + (ACC_W + 1)'(emul_x);

  emul_lat_cnt #(
    .CW (CW)
  ) u_lat_cnt (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable_i   (enable),
    .load_i     (cnt_load),
    .load_val_i (LOAD_VAL),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    x_d      = x_q;
    ovf_d    = ovf_q;
    emul_a_d = emul_a_q;
    emul_b_d = emul_b_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    // Clear lands before any accept in the same cycle, so a MAC started now sums onto zero.
    if (ready_w && clear_acc) begin
      x_d   = '0;
      ovf_d = 1'b0;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = WAIT;
          emul_a_d = a;
          emul_b_d = b;
          mode_d   = mode;
          cnt_load = 1'b1;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          state_d = DONE;
          if (mode_q == MODE_MAC) begin
            x_d   = mac_sum[ACC_W-1:0];
            ovf_d = ovf_q | mac_sum[ACC_W];
          end else begin
            x_d   = ACC_W'(emul_x);
            ovf_d = 1'b0;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mode_q   <= MODE_MUL;
      x_q      <= '0;
      ovf_q    <= 1'b0;
      emul_a_q <= '0;
      emul_b_q <= '0;
    end else if (enable) begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      x_q      <= x_d;
      ovf_q    <= ovf_d;
      emul_a_q <= emul_a_d;
      emul_b_q <= emul_b_d;
    end
  end

  assign ready  = ready_w;
  assign done   = (state_q == DONE);
  assign x      = x_q;
  assign ovf    = ovf_q;
  assign emul_a = emul_a_q;
  assign emul_b = emul_b_q;

endmodule

// File: tb/tb_emul_seq_param.sv
// Scoreboard bench for emul_seq_param with an arithmetic accumulator model
// and a one-register multiplier model behind the emul port.
module tb_emul_seq_param;

  localparam int WIDTH = 8;
  localparam int LAT   = 2;
  localparam int GUARD = 4;
  localparam int ACC_W = 2 * WIDTH + GUARD;
  localparam longint ACC_MOD = longint'(1) << ACC_W;

  logic               clock;
  logic               reset_n;
  logic               enable;
  logic               start;
  logic               mode;
  logic               clear_acc;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               ready;
  logic               done;
  logic [ACC_W-1:0]   x;
  logic               ovf;
  logic [WIDTH-1:0]   emul_a;
  logic [WIDTH-1:0]   emul_b;
  logic [2*WIDTH-1:0] emul_x;

  typedef struct {
    longint x;
    bit     ovf;
    longint cyc;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint acc_m = 0;
  bit     ovf_m = 0;

  emul_seq_param #(
    .WIDTH     (WIDTH),
    .LATENCY   (LAT),
    .ACC_GUARD (GUARD)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .start     (start),
    .mode      (mode),
    .clear_acc (clear_acc),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done      (done),
    .x         (x),
    .ovf       (ovf),
    .emul_a    (emul_a),
    .emul_b    (emul_b),
    .emul_x    (emul_x)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    cyc    <= cyc + 1;
    emul_x <= emul_a * emul_b;
  end

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: done high with no outstanding operation (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_x", longint'(x), e.x);
        chk("done_ovf", longint'(ovf), longint'(e.ovf));
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic m, input logic clr, input int stall, input bit poke);
    int   n;
    exp_t e;
    longint prod;
    longint x_hold;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    start     = 1'b1;
    a         = av;
    b         = bv;
    mode      = m;
    clear_acc = clr;
    if (clr) begin
      acc_m = 0;
      ovf_m = 0;
    end
    x_hold = acc_m;
    prod   = longint'(av) * longint'(bv);
    if (m) begin
      acc_m = acc_m + prod;
      if (acc_m >= ACC_MOD) ovf_m = 1;
      acc_m = acc_m % ACC_MOD;
    end else begin
      acc_m = prod;
      ovf_m = 0;
    end
    e.x   = acc_m;
    e.ovf = ovf_m;
    e.cyc = cyc + 1 + LAT + stall;
    exp_q.push_back(e);
    @(negedge clock);
    start     = 1'b0;
    clear_acc = 1'b0;
    chk("emul_a_load", longint'(emul_a), longint'(av));
    chk("emul_b_load", longint'(emul_b), longint'(bv));
    chk("busy_after_accept", longint'(ready), 0);
    if (stall > 0) begin
      enable = 1'b0;
      repeat (stall) begin
        @(negedge clock);
        chk("x_hold_stall", longint'(x), x_hold);
      end
      enable = 1'b1;
    end
    if (poke) begin
      start = 1'b1;
      a     = ~av;
      b     = ~bv;
      mode  = ~m;
      @(negedge clock);
      start = 1'b0;
      chk("emul_a_ignore", longint'(emul_a), longint'(av));
      chk("emul_b_ignore", longint'(emul_b), longint'(bv));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    @(negedge clock);
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    clear_acc = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clock);
    chk("rst_x", longint'(x), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_ready", longint'(ready), 1);
    chk("rst_emul_a", longint'(emul_a), 0);
    chk("rst_emul_b", longint'(emul_b), 0);
    reset_n = 1'b1;
    @(negedge clock);

    do_op(8'd12, 8'd13, 1'b0, 1'b0, 0, 0);
    drain();
    chk("mul_12x13", longint'(x), 156);

    do_op(8'd255, 8'd255, 1'b1, 1'b1, 0, 0);
    repeat (2) do_op(8'd255, 8'd255, 1'b1, 1'b0, 0, 0);
    drain();
    chk("mac3_x", longint'(x), 195075);
    chk("mac3_ovf", longint'(ovf), 0);
    do_op(8'd255, 8'd255, 1'b1, 1'b1, 0, 0);
    repeat (16) do_op(8'd255, 8'd255, 1'b1, 1'b0, 0, 0);
    drain();
    chk("mac17_x", longint'(x), 56849);
    chk("mac17_ovf", longint'(ovf), 1);

    do_op(8'd3, 8'd5, 1'b0, 1'b0, 3, 0);
    drain();
    chk("stall_mul_x", longint'(x), 15);

    do_op(8'd7, 8'd9, 1'b0, 1'b0, 0, 1);
    do_op(8'd11, 8'd2, 1'b1, 1'b0, 0, 0);
    drain();
    chk("b2b_x", longint'(x), 85);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
            ($urandom_range(0, 4) == 0));
    end
    drain();

    do_op(8'd200, 8'd100, 1'b1, 1'b0, 0, 0);
    reset_n = 1'b0;
    exp_q.delete();
    acc_m = 0;
    ovf_m = 0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("abort_x", longint'(x), 0);
    chk("abort_ovf", longint'(ovf), 0);
    chk("abort_ready", longint'(ready), 1);
    chk("abort_done", longint'(done), 0);
    chk("abort_emul_a", longint'(emul_a), 0);
    repeat (6) @(negedge clock);
    chk("abort_no_done", longint'(done), 0);

    do_op(8'd4, 8'd6, 1'b1, 1'b0, 0, 0);
    drain();
    chk("post_abort_mac", longint'(x), 24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
